// File: rtl/rans_pkg.sv
// Shared rANS constants and decoder state encoding, used by both the encoder and the decoder.
package rans_pkg;

  localparam int RES_DEFAULT  = 10;
  localparam int SYMB_DEFAULT = 8;
  localparam int CNT_DEFAULT  = 16;

  // Coder state x is kept in [L_MIN, L_MAX); M is the total frequency.
  localparam int M           = 1 << RES_DEFAULT;
  localparam int L_MIN       = M;
  localparam int L_MAX       = M << SYMB_DEFAULT;
  localparam int STATE_WIDTH = RES_DEFAULT + SYMB_DEFAULT;

  // Decoder FSM encoding, kept as plain constants so older tools and dumps read the same codes.
  typedef logic [2:0] dec_state_t;
  localparam dec_state_t ST_IDLE    = 3'd0;
  localparam dec_state_t ST_FILL    = 3'd1;
  localparam dec_state_t ST_LK_SLOT = 3'd2;
  localparam dec_state_t ST_LK_FREQ = 3'd3;
  localparam dec_state_t ST_EMIT    = 3'd4;
  localparam dec_state_t ST_RENORM  = 3'd5;
  localparam dec_state_t ST_DONE    = 3'd6;

endpackage

// File: rtl/rans_slot_table.sv
// Slot-to-symbol lookup RAM: one entry per frequency slot, filled one slot per cycle and read
// with one cycle of latency.
module rans_slot_table #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  // Single-port RAM with synchronous write and registered read.
  // NOTE: the storage array has no reset branch; the contents survive reset by design and a
  // reset loop would stop the array mapping onto a RAM macro.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/rans_dec.sv
// rANS decoder: consumes the encoder's final state and its bytes last-emitted-first, and
// regenerates the symbols last-encoded-first over a ready/valid output.
module rans_dec
  import rans_pkg::*;
#(
  parameter int RESOLUTION   = RES_DEFAULT,
  parameter int SYMBOL_WIDTH = SYMB_DEFAULT,
  parameter int CNT_WIDTH    = CNT_DEFAULT
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               freq_wr_i,
  input  logic [RESOLUTION-1:0]              freq_i,
  input  logic [RESOLUTION-1:0]              cum_freq_i,
  input  logic [SYMBOL_WIDTH-1:0]            symb_i,
  output logic                               freq_rdy_o,
  input  logic                               start_i,
  input  logic [RESOLUTION+SYMBOL_WIDTH-1:0] state_i,
  input  logic [CNT_WIDTH-1:0]               count_i,
  input  logic                               byte_valid_i,
  input  logic [SYMBOL_WIDTH-1:0]            byte_i,
  output logic                               byte_ready_o,
  output logic                               sym_valid_o,
  output logic [SYMBOL_WIDTH-1:0]            sym_o,
  input  logic                               sym_ready_i,
  output logic                               busy_o,
  output logic                               done_o
);

  localparam int SW = RESOLUTION + SYMBOL_WIDTH;

  dec_state_t                  state_q;
  logic [SW-1:0]               x_q;
  logic [CNT_WIDTH-1:0]        count_q;
  logic [SYMBOL_WIDTH-1:0]     sym_q;
  logic [RESOLUTION-1:0]       fill_ptr_q;
  logic [RESOLUTION-1:0]       fill_left_q;
  logic [SYMBOL_WIDTH-1:0]     fill_sym_q;
  logic [2*RESOLUTION-1:0]     freq_mem [2**SYMBOL_WIDTH];
  logic [2*RESOLUTION-1:0]     freq_rd_q;

  logic                        slot_we;
  logic [RESOLUTION-1:0]       slot_addr;
  logic [SYMBOL_WIDTH-1:0]     slot_rdata;
  logic [RESOLUTION-1:0]       f_rd;
  logic [RESOLUTION-1:0]       c_rd;
  logic [SW-1:0]               x_dec;
  logic [SW-1:0]               x_shift;
  logic [CNT_WIDTH-1:0]        count_dec;
  logic                        x_dec_low;
  logic                        x_shift_low;

  // The slot RAM is written while filling and otherwise addressed by the low bits of x.
  assign slot_we   = (state_q == ST_FILL) && !rst_i;
  assign slot_addr = (state_q == ST_FILL) ? fill_ptr_q : x_q[RESOLUTION-1:0];

  rans_slot_table #(
    .ADDR_WIDTH (RESOLUTION),
    .DATA_WIDTH (SYMBOL_WIDTH)
  ) u_slot_table (
    .clk_i   (clk_i),
    .we_i    (slot_we),
    .addr_i  (slot_addr),
    .wdata_i (fill_sym_q),
    .rdata_o (slot_rdata)
  );

  // Decode step: x' = f*(x>>RES) + (x mod M) - c, evaluated at full state width.
  assign {f_rd, c_rd} = freq_rd_q;
  assign x_dec = ({{SYMBOL_WIDTH{1'b0}}, f_rd} * {{RESOLUTION{1'b0}}, x_q[SW-1:RESOLUTION]})
               + {{SYMBOL_WIDTH{1'b0}}, x_q[RESOLUTION-1:0]}
               - {{SYMBOL_WIDTH{1'b0}}, c_rd};
  assign x_shift     = {x_q[RESOLUTION-1:0], byte_i};
  assign x_dec_low   = (x_dec[SW-1:RESOLUTION] == '0);
  assign x_shift_low = (x_shift[SW-1:RESOLUTION] == '0);
  assign count_dec   = count_q - 1'b1;

  assign freq_rdy_o   = (state_q == ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);
  assign sym_valid_o  = (state_q == ST_EMIT);
  assign done_o       = (state_q == ST_DONE);
  assign byte_ready_o = (state_q == ST_RENORM) && byte_valid_i;
  assign sym_o        = sym_q;

  // Frequency table: written from IDLE, read once per symbol in LK_FREQ; never cleared.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == ST_IDLE && freq_wr_i) begin
      freq_mem[symb_i] <= {freq_i, cum_freq_i};
    end
    if (state_q == ST_LK_FREQ) begin
      freq_rd_q <= freq_mem[slot_rdata];
    end
  end

  // Control FSM together with the x, count, output-symbol and fill-pointer registers.
  // NOTE: every register here is updated with <= so all of them see the pre-edge values of
  // x_q and count_q within one cycle, regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      count_q     <= '0;
      sym_q       <= '0;
      fill_ptr_q  <= '0;
      fill_left_q <= '0;
      fill_sym_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (freq_wr_i) begin
            fill_ptr_q  <= cum_freq_i;
            fill_left_q <= freq_i;
            fill_sym_q  <= symb_i;
            if (freq_i != '0) state_q <= ST_FILL;
          end else if (start_i) begin
            x_q     <= state_i;
            count_q <= count_i;
            state_q <= (count_i == '0) ? ST_DONE : ST_LK_SLOT;
          end
        end
        ST_FILL: begin
          fill_ptr_q  <= fill_ptr_q + 1'b1;
          fill_left_q <= fill_left_q - 1'b1;
          if (fill_left_q == RESOLUTION'(1)) state_q <= ST_IDLE;
        end
        ST_LK_SLOT: state_q <= ST_LK_FREQ;
        ST_LK_FREQ: begin
          sym_q   <= slot_rdata;
          state_q <= ST_EMIT;
        end
        ST_EMIT: begin
          if (sym_ready_i) begin
            x_q     <= x_dec;
            count_q <= count_dec;
            if (x_dec_low)              state_q <= ST_RENORM;
            else if (count_dec == '0)   state_q <= ST_DONE;
            else                        state_q <= ST_LK_SLOT;
          end
        end
        ST_RENORM: begin
          if (byte_valid_i) begin
            x_q <= x_shift;
            if (!x_shift_low) state_q <= (count_q == '0) ? ST_DONE : ST_LK_SLOT;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
